alimentador_bandeja: RTL and testbench

//  Upstream feed controller for the tray counter (units/tens BCD, counts 99 -> 00).

---
 rtl/alimentador_bandeja_pkg.sv | 18 +
 rtl/alimentador_bandeja_sync_2ff.sv | 26 ++
 rtl/alimentador_bandeja.sv | 168 ++++++++++++++++
 tb/tb_alimentador_bandeja.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alimentador_bandeja_pkg.sv
// Shared definitions for the tray feed controller.
// Holds the FSM state encoding (also the value shown on the estado port), the
// width of that encoding and the BCD digit width of the tray counter read-back.
package alimentador_bandeja_pkg;

  localparam int unsigned EstadoWidth = 3;
  localparam int unsigned BcdWidth    = 4;

  typedef enum logic [EstadoWidth-1:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StConfirm = 3'd2,
    StRelease = 3'd3,
    StEmpty   = 3'd4,
    StFault   = 3'd5
  } estado_e;

endpackage

// File: rtl/alimentador_bandeja_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, clears both flops
//   d    asynchronous input
//   q    synchronised output, two clock cycles behind d
module alimentador_bandeja_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alimentador_bandeja.sv
// Feed controller in front of the BCD tray counter.
// Runs the feed motor, synchronises and debounces the item sensor, issues one
// single-cycle decrement strobe per item, stops when the tray reads 00 and
// latches a jam fault when no progress is made for TIMEOUT_CYCLES.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   iniciar, parar       start / stop request levels (parar wins)
//   sensor               raw asynchronous item sensor, 1 = item present
//   unidades_bandeja     tray counter units digit (BCD)
//   dezenas_bandeja      tray counter tens digit (BCD)
//   motor                feed motor enable
//   dec                  1-cycle decrement strobe to the tray counter
//   vazia                tray empty
//   falha                jam fault, sticky until reset
//   estado               current state encoding
// DEBOUNCE_CYCLES is expected to be at least 2.
module alimentador_bandeja
  import alimentador_bandeja_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50_000,
  parameter int unsigned TIMEOUT_CYCLES  = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iniciar,
  input  logic                   parar,
  input  logic                   sensor,
  input  logic [BcdWidth-1:0]    unidades_bandeja,
  input  logic [BcdWidth-1:0]    dezenas_bandeja,
  output logic                   motor,
  output logic                   dec,
  output logic                   vazia,
  output logic                   falha,
  output logic [EstadoWidth-1:0] estado
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  // Comparing against N-1 before the increment means the Nth sample decides.
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  estado_e         state_q;
  logic [DebW-1:0] deb_q;
  logic [TmoW-1:0] tmo_q;
  logic            s_sync;
  logic            cnt_zero;

  alimentador_bandeja_sync_2ff u_sync_2ff (
    .clk (clk),
    .rst (rst),
    .d   (sensor),
    .q   (s_sync)
  );

  assign cnt_zero = (unidades_bandeja == '0) && (dezenas_bandeja == '0);
  assign estado   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      deb_q   <= '0;
      tmo_q   <= '0;
      motor   <= 1'b0;
      dec     <= 1'b0;
      vazia   <= 1'b0;
      falha   <= 1'b0;
    end else begin
      dec <= 1'b0;
      case (state_q)
        StIdle: begin
          if (iniciar && !parar) begin
            if (cnt_zero) begin
              state_q <= StEmpty;
              vazia   <= 1'b1;
            end else begin
              state_q <= StRun;
              tmo_q   <= '0;
              motor   <= 1'b1;
            end
          end
        end

        StRun: begin
          tmo_q <= tmo_q + 1'b1;
          if (parar) begin
            state_q <= StIdle;
            motor   <= 1'b0;
          end else if (tmo_q == TmoLast) begin
            state_q <= StFault;
            motor   <= 1'b0;
            falha   <= 1'b1;
          end else if (s_sync) begin
            // This sample already counts as the first stable one.
            state_q <= StConfirm;
            deb_q   <= DebW'(1);
          end
        end

        StConfirm: begin
          if (parar) begin
            state_q <= StIdle;
            motor   <= 1'b0;
          end else if (!s_sync) begin
            // Glitch: back to RUN without forgiving the elapsed timeout.
            state_q <= StRun;
          end else if (deb_q == DebLast) begin
            state_q <= StRelease;
            dec     <= 1'b1;
            deb_q   <= '0;
            tmo_q   <= '0;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end

        StRelease: begin
          tmo_q <= tmo_q + 1'b1;
          if (parar) begin
            state_q <= StIdle;
            motor   <= 1'b0;
          end else if (tmo_q == TmoLast) begin
            // Sensor stuck high.
            state_q <= StFault;
            motor   <= 1'b0;
            falha   <= 1'b1;
          end else if (s_sync) begin
            deb_q <= '0;
          end else if (deb_q == DebLast) begin
            // Counter has long settled after dec, so cnt_zero is trustworthy here.
            deb_q <= '0;
            if (cnt_zero) begin
              state_q <= StEmpty;
              motor   <= 1'b0;
              vazia   <= 1'b1;
            end else begin
              state_q <= StRun;
              tmo_q   <= '0;
            end
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end

        StEmpty: begin
          if (!cnt_zero) begin
            state_q <= StIdle;
            vazia   <= 1'b0;
          end
        end

        StFault: begin
          // Sticky until reset.
        end

        default: begin
          state_q <= StIdle;
          deb_q   <= '0;
          tmo_q   <= '0;
          motor   <= 1'b0;
          vazia   <= 1'b0;
          falha   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alimentador_bandeja.sv
// Bench for alimentador_bandeja with short debounce/timeout values.
// A behavioural model tracks the expected mode each cycle and every output is
// compared against it; directed scenarios add literal expectations on top.
// The tray counter is modelled as an integer decremented on each dec pulse.
module tb_alimentador_bandeja;
  import alimentador_bandeja_pkg::*;

  localparam int Deb = 4;
  localparam int Tmo = 50;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       iniciar = 1'b0;
  logic       parar   = 1'b0;
  logic       sensor  = 1'b0;
  logic [3:0] unid;
  logic [3:0] dez;
  logic       motor;
  logic       dec;
  logic       vazia;
  logic       falha;
  logic [2:0] estado;

  int tray     = 99;
  int n_cmp    = 0;
  int n_bad    = 0;
  int dec_seen = 0;

  // Model state: mode uses the externally visible state numbering.
  int m_mode  = 0;
  int m_prev  = 0;
  int m_hold  = 0;
  int m_stall = 0;
  bit m_sh0   = 1'b0;
  bit m_sh1   = 1'b0;

  always #5 clk = ~clk;

  assign unid = 4'(tray % 10);
  assign dez  = 4'(tray / 10);

  alimentador_bandeja #(
    .DEBOUNCE_CYCLES (Deb),
    .TIMEOUT_CYCLES  (Tmo)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .iniciar          (iniciar),
    .parar            (parar),
    .sensor           (sensor),
    .unidades_bandeja (unid),
    .dezenas_bandeja  (dez),
    .motor            (motor),
    .dec              (dec),
    .vazia            (vazia),
    .falha            (falha),
    .estado           (estado)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, seen from the outside.
  task automatic model_step();
    bit s;
    bit zero;
    bit expired;
    s     = m_sh1;
    m_sh1 = m_sh0;
    m_sh0 = sensor;
    zero  = (tray == 0);
    m_prev = m_mode;
    if (rst) begin
      m_mode  = 0;
      m_hold  = 0;
      m_stall = 0;
      m_sh0   = 1'b0;
      m_sh1   = 1'b0;
      return;
    end
    expired = (m_stall == Tmo - 1);
    case (m_mode)
      0: if (iniciar && !parar) begin
        if (zero) m_mode = 4;
        else begin
          m_mode  = 1;
          m_stall = 0;
        end
      end
      1: begin
        m_stall++;
        if (parar) m_mode = 0;
        else if (expired) m_mode = 5;
        else if (s) begin
          m_mode = 2;
          m_hold = 1;
        end
      end
      2: begin
        if (parar) m_mode = 0;
        else if (!s) m_mode = 1;
        else if (m_hold + 1 == Deb) begin
          m_mode  = 3;
          m_hold  = 0;
          m_stall = 0;
        end else m_hold++;
      end
      3: begin
        m_stall++;
        if (parar) m_mode = 0;
        else if (expired) m_mode = 5;
        else if (s) m_hold = 0;
        else if (m_hold + 1 == Deb) begin
          m_hold = 0;
          if (zero) m_mode = 4;
          else begin
            m_mode  = 1;
            m_stall = 0;
          end
        end else m_hold++;
      end
      4: if (!zero) m_mode = 0;
      default: ;
    endcase
  endtask

  // Per-cycle compare against the model; also acts as the tray counter.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("cyc_estado", 32'(estado), m_mode);
      check("cyc_motor", 32'(motor), 32'(m_mode inside {1, 2, 3}));
      check("cyc_dec", 32'(dec), 32'(m_prev == 2 && m_mode == 3));
      check("cyc_vazia", 32'(vazia), 32'(m_mode == 4));
      check("cyc_falha", 32'(falha), 32'(m_mode == 5));
      if (dec === 1'b1) begin
        dec_seen++;
        if (tray > 0) tray = tray - 1;
      end
    end
  end

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  task automatic item(input int hi, input int lo);
    sensor = 1'b1;
    repeat (hi) @(negedge clk);
    sensor = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_estado(input logic [2:0] target, input int budget, input string name);
    int k;
    k = 0;
    while (estado !== target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(estado), 32'(target));
  endtask

  initial begin
    int d0;
    // 1: reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t1_estado", 32'(estado), 0);
    check("t1_motor", 32'(motor), 0);
    check("t1_dec", 32'(dec), 0);
    check("t1_vazia", 32'(vazia), 0);
    check("t1_falha", 32'(falha), 0);

    // 2: one clean item
    pulse_iniciar();
    check("t2_run", 32'(estado), 1);
    item(10, 10);
    check("t2_decs", dec_seen, 1);
    check("t2_tray", tray, 98);
    check("t2_estado", 32'(estado), 1);
    check("t2_motor", 32'(motor), 1);

    // 3: glitch then three items
    item(2, 6);
    check("t3_glitch_estado", 32'(estado), 1);
    check("t3_glitch_decs", dec_seen, 1);
    repeat (3) item(6, 8);
    check("t3_decs", dec_seen, 4);
    check("t3_tray", tray, 95);
    check("t3_estado", 32'(estado), 1);

    // 4: last item empties the tray, then reload
    tray = 1;
    item(6, 10);
    wait_estado(3'd4, 20, "t4_empty");
    check("t4_vazia", 32'(vazia), 1);
    check("t4_motor", 32'(motor), 0);
    check("t4_tray", tray, 0);
    check("t4_decs", dec_seen, 5);
    tray = 99;
    @(negedge clk);
    check("t4_reload_estado", 32'(estado), 0);
    check("t4_reload_vazia", 32'(vazia), 0);

    // 5: jam timeout
    pulse_iniciar();
    repeat (49) @(negedge clk);
    check("t5_still_run", 32'(estado), 1);
    @(negedge clk);
    check("t5_fault", 32'(estado), 5);
    check("t5_falha", 32'(falha), 1);
    check("t5_motor", 32'(motor), 0);
    pulse_iniciar();
    @(negedge clk);
    check("t5_sticky", 32'(estado), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_estado", 32'(estado), 0);
    check("t5_rst_falha", 32'(falha), 0);

    // 6: stop during confirmation, then start+stop together
    pulse_iniciar();
    sensor = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_confirm", 32'(estado), 2);
    @(negedge clk);
    parar = 1'b1;
    d0 = dec_seen;
    @(negedge clk);
    check("t6_stop_estado", 32'(estado), 0);
    check("t6_stop_motor", 32'(motor), 0);
    sensor  = 1'b0;
    iniciar = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_both_estado", 32'(estado), 0);
    check("t6_no_dec", dec_seen, d0);
    iniciar = 1'b0;
    parar   = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
